// File: rtl/qspi_ram_slave_sync.sv
// rtl/qspi_ram_slave_sync.sv - system-clocked SPI/QSPI RAM target with synchronous host port
//
// The SPI pins are oversampled in the clk domain. spi_clk, spi_select and spi_d_in all pass
// through the same synchroniser depth, so data and clock stay aligned relative to each other.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   spi_clk, spi_select   SPI clock (mode 0) and chip select (high = deselected)
//   spi_d_in[3:0]         D3..D0 from the host; D0 = MOSI
//   spi_d_out[3:0]        D3..D0 toward the host; D1 = MISO in single mode
//   spi_d_oe[3:0]         per-lane output enable
//   host_addr/we/wdata    fabric-side byte write port
//   host_rdata            registered read of ram[host_addr]
//   busy                  selected and the FSM is not idle
module qspi_ram_slave_sync #(
    parameter int RAM_ADDR_BITS = 6,
    parameter int ADDR_BYTES    = 3,
    parameter int DUMMY_CYCLES  = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_clk,
    input  logic                     spi_select,
    input  logic [3:0]               spi_d_in,
    output logic [3:0]               spi_d_out,
    output logic [3:0]               spi_d_oe,
    input  logic [RAM_ADDR_BITS-1:0] host_addr,
    input  logic                     host_we,
    input  logic [7:0]               host_wdata,
    output logic [7:0]               host_rdata,
    output logic                     busy
);

    localparam int DEPTH      = 1 << RAM_ADDR_BITS;
    localparam int ADDR_RISES = 8 * ADDR_BYTES;
    localparam int CNT_MAX    = (ADDR_RISES > DUMMY_CYCLES) ? ADDR_RISES : DUMMY_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_QUAD_WR   = 8'h32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers: {select, clk, d[3:0]} per stage.
    // ------------------------------------------------------------------
    logic [5:0] sync_q [SYNC_STAGES];
    logic       sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 6'b100000;
            end
            sclk_prev <= 1'b0;
        end else begin
            sync_q[0] <= {spi_select, spi_clk, spi_d_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev <= sync_q[SYNC_STAGES-1][4];
        end
    end

    logic       sel_n_s;
    logic       sclk_s;
    logic [3:0] din_s;
    logic       spi_rise;
    logic       spi_fall;

    assign sel_n_s  = sync_q[SYNC_STAGES-1][5];
    assign sclk_s   = sync_q[SYNC_STAGES-1][4];
    assign din_s    = sync_q[SYNC_STAGES-1][3:0];
    assign spi_rise = sclk_s & ~sclk_prev;
    assign spi_fall = ~sclk_s & sclk_prev;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0] mem [DEPTH];

    state_t                   state;
    logic [7:0]               cmd_sr;
    logic [CNT_W-1:0]         cnt;
    logic [RAM_ADDR_BITS-1:0] addr_sr;
    logic [RAM_ADDR_BITS-1:0] ptr;
    logic                     quad;
    logic [7:0]               tx_sr;
    logic [7:0]               rx_sr;

    logic [7:0]               cmd_next;
    logic [RAM_ADDR_BITS-1:0] addr_next;
    logic                     byte_last;
    logic                     spi_we;
    logic [7:0]               spi_wdata;

    assign cmd_next  = {cmd_sr[6:0], din_s[0]};
    assign addr_next = {addr_sr[RAM_ADDR_BITS-2:0], din_s[0]};
    // A byte takes two nibble rises in quad mode, eight bit rises in single mode.
    assign byte_last = quad ? (cnt == CNT_W'(1)) : (cnt == CNT_W'(7));
    assign spi_wdata = quad ? {rx_sr[3:0], din_s} : {rx_sr[6:0], din_s[0]};
    // Commit is combinational so it lands on the same clk edge as the completing rise,
    // which lets the RAM port arbitrate it against host_we in that cycle.
    assign spi_we    = !sel_n_s && spi_rise && (state == ST_WRITE) && byte_last;

    // SPI commit takes priority over a host write to the same byte.
    always_ff @(posedge clk) begin
        if (spi_we) begin
            mem[ptr] <= spi_wdata;
        end
        if (host_we && !(spi_we && (ptr == host_addr))) begin
            mem[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rdata <= 8'h00;
        end else begin
            host_rdata <= mem[host_addr];
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_sr    <= 8'h00;
            cnt       <= '0;
            addr_sr   <= '0;
            ptr       <= '0;
            quad      <= 1'b0;
            tx_sr     <= 8'h00;
            rx_sr     <= 8'h00;
            spi_d_out <= 4'b0000;
            spi_d_oe  <= 4'b0000;
            busy      <= 1'b0;
        end else if (sel_n_s) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            quad      <= 1'b0;
            spi_d_out <= 4'b0000;
            spi_d_oe  <= 4'b0000;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_CMD;
                    cnt      <= '0;
                    spi_d_oe <= 4'b0010;
                    busy     <= 1'b1;
                end

                ST_CMD: begin
                    if (spi_rise) begin
                        cmd_sr <= cmd_next;
                        if (cnt == CNT_W'(7)) begin
                            cnt  <= '0;
                            quad <= (cmd_next == CMD_QUAD_READ) || (cmd_next == CMD_QUAD_WR);
                            case (cmd_next)
                                CMD_READ, CMD_FAST_READ, CMD_QUAD_READ, CMD_WRITE: begin
                                    state <= ST_ADDR;
                                end
                                CMD_QUAD_WR: begin
                                    state    <= ST_ADDR;
                                    spi_d_oe <= 4'b0000;
                                end
                                default: begin
                                    state    <= ST_IGNORE;
                                    spi_d_oe <= 4'b0000;
                                end
                            endcase
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_ADDR: begin
                    if (spi_rise) begin
                        addr_sr <= addr_next;
                        if (cnt == CNT_W'(ADDR_RISES - 1)) begin
                            cnt <= '0;
                            case (cmd_sr)
                                CMD_READ: begin
                                    state <= ST_READ;
                                    tx_sr <= mem[addr_next];
                                    ptr   <= addr_next + RAM_ADDR_BITS'(1);
                                end
                                CMD_FAST_READ, CMD_QUAD_READ: begin
                                    state <= ST_DUMMY;
                                    ptr   <= addr_next;
                                end
                                default: begin
                                    state <= ST_WRITE;
                                    ptr   <= addr_next;
                                end
                            endcase
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DUMMY: begin
                    if (spi_rise) begin
                        if (cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                            cnt   <= '0;
                            state <= ST_READ;
                            tx_sr <= mem[ptr];
                            ptr   <= ptr + RAM_ADDR_BITS'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_READ: begin
                    // tx_sr is loaded on the rise; the fall presents its MSB bit/nibble.
                    if (spi_rise) begin
                        if (byte_last) begin
                            cnt   <= '0;
                            tx_sr <= mem[ptr];
                            ptr   <= ptr + RAM_ADDR_BITS'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (spi_fall) begin
                        if (quad) begin
                            spi_d_out <= tx_sr[7:4];
                            spi_d_oe  <= 4'b1111;
                            tx_sr     <= {tx_sr[3:0], 4'b0000};
                        end else begin
                            spi_d_out <= {2'b00, tx_sr[7], 1'b0};
                            tx_sr     <= {tx_sr[6:0], 1'b0};
                        end
                    end
                end

                ST_WRITE: begin
                    if (spi_rise) begin
                        rx_sr <= spi_wdata;
                        if (byte_last) begin
                            cnt <= '0;
                            ptr <= ptr + RAM_ADDR_BITS'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_IGNORE: begin
                    spi_d_oe <= 4'b0000;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
